cv32e40p_instr_prefetch_queue: RTL and testbench

Word-granular instruction prefetcher between the OBI instruction port and the IF-stage aligner. It issues sequential 32-bit fetches and tracks outstanding transactions. Returned words are buffered in a small FIFO. On a branch, the FIFO is flushed, responses still in flight are discarded, and fetching restarts at the new target. It drives the `fetch_valid/fetch_ready/fetch_rdata` handshake consumed by the IF stage.

---
 rtl/cv32e40p_instr_prefetch_queue.sv | 105 ++++++++++
 tb/tb_cv32e40p_instr_prefetch_queue.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_instr_prefetch_queue.sv
// cv32e40p_instr_prefetch_queue: OBI word prefetcher (req FSM + outstanding/discard tracking + DEPTH-entry FIFO to IF); define CV32E40P_PREFETCH_ERR_EN to carry instr_err_i through to fetch_err_o
module cv32e40p_instr_prefetch_queue #(
    parameter int DEPTH = 2,
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_i,
    input  logic        branch_i,
    input  logic [31:0] branch_addr_i,
    input  logic        fetch_ready_i,
    output logic        fetch_valid_o,
    output logic [31:0] fetch_rdata_o,
    output logic        fetch_err_o,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    input  logic        instr_err_i,
    output logic        busy_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);
`ifdef CV32E40P_PREFETCH_ERR_EN
    localparam int W = 33;
`else
    localparam int W = 32;
`endif
    typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_GNT_BR} state_t;
    state_t        state;
    logic [31:0]   fetch_addr, pend_addr, tgt;
    logic [CW-1:0] outstanding, discard, count;
    logic [PW-1:0] rptr, wptr;
    logic [W-1:0]  mem [DEPTH];
    logic [W-1:0]  wdata;
    logic [CW:0]   used;
    logic          pop, push, gnt, old_gnt;
    assign tgt           = {branch_addr_i[31:2], 2'b00};
    assign fetch_valid_o = count != '0;
    assign fetch_rdata_o = mem[rptr][31:0];
`ifdef CV32E40P_PREFETCH_ERR_EN
    assign wdata       = {instr_err_i, instr_rdata_i};
    assign fetch_err_o = mem[rptr][32];
`else
    assign wdata       = instr_rdata_i;
    assign fetch_err_o = 1'b0 & instr_err_i;
`endif
    assign pop  = fetch_valid_o && fetch_ready_i && !branch_i;
    assign push = instr_rvalid_i && discard == '0 && !branch_i;
    // Words that will occupy the FIFO: buffered plus live in-flight, crediting a same-cycle pop so a
    // zero-wait memory sustains one word per cycle; a branch leaves nothing live.
    assign used = branch_i ? '0
                : {1'b0, count} + {1'b0, outstanding} - {1'b0, discard} - {{CW{1'b0}}, pop};
    assign instr_req_o  = state != IDLE
                       || (req_i && outstanding < CW'(MAX_OUTSTANDING) && used < (CW+1)'(DEPTH));
    assign instr_addr_o = (state == IDLE && branch_i) ? tgt : fetch_addr;
    assign gnt          = instr_req_o && instr_gnt_i;
    assign old_gnt      = gnt && state != IDLE;
    assign busy_o       = instr_req_o || outstanding != '0;
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            fetch_addr  <= '0;
            pend_addr   <= '0;
            outstanding <= '0;
            discard     <= '0;
            count       <= '0;
            rptr        <= '0;
            wptr        <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            outstanding <= outstanding + CW'(gnt) - CW'(instr_rvalid_i);
            discard     <= branch_i ? outstanding + CW'(old_gnt) - CW'(instr_rvalid_i)
                         : discard + CW'(gnt && state == WAIT_GNT_BR) - CW'(instr_rvalid_i && discard != '0);
            count       <= branch_i ? '0 : count + CW'(push) - CW'(pop);
            wptr        <= branch_i ? '0 : wptr + PW'(push);
            rptr        <= branch_i ? '0 : rptr + PW'(pop);
            if (push) mem[wptr] <= wdata;
            case (state)
                IDLE: begin
                    fetch_addr <= gnt ? instr_addr_o + 32'd4 : instr_addr_o;
                    state      <= (instr_req_o && !instr_gnt_i) ? WAIT_GNT : IDLE;
                end
                WAIT_GNT: begin
                    if (gnt) begin
                        fetch_addr <= branch_i ? tgt : fetch_addr + 32'd4;
                        state      <= IDLE;
                    end else if (branch_i) begin
                        pend_addr <= tgt;
                        state     <= WAIT_GNT_BR;
                    end
                end
                WAIT_GNT_BR: begin
                    if (branch_i) pend_addr <= tgt;
                    if (gnt) begin
                        fetch_addr <= branch_i ? tgt : pend_addr;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_cv32e40p_instr_prefetch_queue.sv
// tb_cv32e40p_instr_prefetch_queue: scoreboard bench with a zero-wait OBI memory model
module tb_cv32e40p_instr_prefetch_queue;
    logic        clk, rst, req_i, branch_i, fetch_ready_i, fetch_valid_o, fetch_err_o;
    logic        instr_req_o, instr_gnt_i, instr_rvalid_i, instr_err_i, busy_o;
    logic [31:0] branch_addr_i, fetch_rdata_o, instr_addr_o, instr_rdata_i;
    typedef struct packed {logic [31:0] d; logic e;} exp_t;
    exp_t        eq[$];
    logic [31:0] mq[$];
    logic        resp_hold;
    logic [31:0] err_addr;
    logic        o_req, o_valid, o_err, o_busy;
    logic [31:0] o_addr, o_rdata;
    int          vectors, miscompares;
    cv32e40p_instr_prefetch_queue #(.DEPTH(2), .MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst), .req_i(req_i), .branch_i(branch_i), .branch_addr_i(branch_addr_i),
        .fetch_ready_i(fetch_ready_i), .fetch_valid_o(fetch_valid_o), .fetch_rdata_o(fetch_rdata_o),
        .fetch_err_o(fetch_err_o), .instr_req_o(instr_req_o), .instr_addr_o(instr_addr_o),
        .instr_gnt_i(instr_gnt_i), .instr_rvalid_i(instr_rvalid_i), .instr_rdata_i(instr_rdata_i),
        .instr_err_i(instr_err_i), .busy_o(busy_o)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    function automatic logic [31:0] word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endfunction
    function automatic logic err_of(input logic [31:0] a);
`ifdef CV32E40P_PREFETCH_ERR_EN
        return a == err_addr;
`else
        return 1'b0;
`endif
    endfunction
    // One clock: observe at negedge, score pops, then drive memory responses just after the edge.
    task automatic cyc();
        exp_t e;
        logic [31:0] a;
        @(negedge clk);
        o_req = instr_req_o; o_addr = instr_addr_o; o_valid = fetch_valid_o;
        o_rdata = fetch_rdata_o; o_err = fetch_err_o; o_busy = busy_o;
        if (!rst && o_req && instr_gnt_i) mq.push_back(o_addr);
        if (!rst && o_valid && fetch_ready_i && !branch_i) begin
            vectors++;
            if (eq.size() == 0) begin
                miscompares++;
                $display("FAIL pop_extra: rdata %h, required no word", o_rdata);
            end else begin
                e = eq.pop_front();
                if (o_rdata !== e.d || o_err !== e.e) begin
                    miscompares++;
                    $display("FAIL pop_data: rdata %h err %b, required %h err %b", o_rdata, o_err, e.d, e.e);
                end
            end
        end
        @(posedge clk);
        #1;
        branch_i = 1'b0;
        if (rst) begin
            mq.delete();
            eq.delete();
        end
        if (!rst && !resp_hold && mq.size() != 0) begin
            a = mq.pop_front();
            instr_rvalid_i = 1'b1; instr_rdata_i = word(a); instr_err_i = a == err_addr;
        end else begin
            instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        end
    endtask
    task automatic do_branch(input logic [31:0] t);
        logic [31:0] b;
        branch_i = 1'b1;
        branch_addr_i = t;
        b = {t[31:2], 2'b00};
        eq.delete();
        for (int k = 0; k < 40; k++) eq.push_back('{d: word(b + 32'(4 * k)), e: err_of(b + 32'(4 * k))});
    endtask
    task automatic test_reset();
        cyc(); cyc();
        for (int p = 0; p < 2; p++) begin
            vectors++;
            if (o_req !== 1'b0 || o_addr !== 32'h0 || o_valid !== 1'b0 || o_rdata !== 32'h0
                || o_err !== 1'b0 || o_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_state: req %b addr %h valid %b rdata %h err %b busy %b, required all 0",
                         o_req, o_addr, o_valid, o_rdata, o_err, o_busy);
            end
            rst = 1'b0;
            cyc();
        end
    endtask
    task automatic test_sequential();
        fetch_ready_i = 1'b1; req_i = 1'b1; instr_gnt_i = 1'b1;
        do_branch(32'h80);
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h80) begin
            miscompares++;
            $display("FAIL seq_branch_req: req %b addr %h, required 1 00000080", o_req, o_addr);
        end
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h84 || o_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL seq_second: req %b addr %h valid %b, required 1 00000084 0", o_req, o_addr, o_valid);
        end
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h88 || o_valid !== 1'b1 || o_rdata !== word(32'h80)) begin
            miscompares++;
            $display("FAIL seq_first_word: req %b addr %h valid %b rdata %h, required 1 00000088 1 %h",
                     o_req, o_addr, o_valid, o_rdata, word(32'h80));
        end
        for (int i = 0; i < 6; i++) begin
            cyc();
            vectors++;
            if (o_req !== 1'b1 || o_addr !== 32'h8C + 32'(4 * i) || o_valid !== 1'b1) begin
                miscompares++;
                $display("FAIL seq_sustain: req %b addr %h valid %b, required 1 %h 1",
                         o_req, o_addr, o_valid, 32'h8C + 32'(4 * i));
            end
        end
    endtask
    task automatic test_stall();
        logic r1;
        fetch_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (i >= 3) begin
                vectors++;
                if (o_req !== 1'b0 || o_busy !== 1'b0 || o_valid !== 1'b1) begin
                    miscompares++;
                    $display("FAIL stall_hold: req %b busy %b valid %b, required 0 0 1", o_req, o_busy, o_valid);
                end
            end
        end
        fetch_ready_i = 1'b1;
        cyc();
        r1 = o_req;
        cyc();
        vectors++;
        if (!(r1 || o_req)) begin
            miscompares++;
            $display("FAIL stall_resume: req %b/%b, required a request after the pop", r1, o_req);
        end
        repeat (8) cyc();
    endtask
    task automatic test_branch_wait();
        logic [31:0] a;
        instr_gnt_i = 1'b0;
        cyc();
        a = o_addr;
        vectors++;
        if (o_req !== 1'b1) begin
            miscompares++;
            $display("FAIL bw_req_held: req %b, required 1", o_req);
        end
        do_branch(32'h200);
        cyc();
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== a) begin
            miscompares++;
            $display("FAIL bw_addr_stable: req %b addr %h, required 1 %h", o_req, o_addr, a);
        end
        instr_gnt_i = 1'b1;
        cyc();
        vectors++;
        if (o_addr !== a) begin
            miscompares++;
            $display("FAIL bw_granted_addr: addr %h, required %h", o_addr, a);
        end
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h200) begin
            miscompares++;
            $display("FAIL bw_target_req: req %b addr %h, required 1 00000200", o_req, o_addr);
        end
        repeat (8) cyc();
    endtask
    task automatic test_branch_outstanding();
        int n;
        resp_hold = 1'b1;
        repeat (5) cyc();
        vectors++;
        if (o_req !== 1'b0 || o_busy !== 1'b1 || o_valid !== 1'b0 || mq.size() != 2) begin
            miscompares++;
            $display("FAIL bo_limit: req %b busy %b valid %b inflight %0d, required 0 1 0 2",
                     o_req, o_busy, o_valid, mq.size());
        end
        do_branch(32'h200);
        cyc();
        resp_hold = 1'b0;
        n = 0;
        do begin
            cyc();
            n++;
        end while (!o_valid && n < 20);
        vectors++;
        if (o_valid !== 1'b1 || o_rdata !== word(32'h200)) begin
            miscompares++;
            $display("FAIL bo_first_word: valid %b rdata %h after %0d cycles, required 1 %h",
                     o_valid, o_rdata, n, word(32'h200));
        end
        repeat (6) cyc();
    endtask
    task automatic test_wrap();
        do_branch(32'hFFFF_FFFE);
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_branch: req %b addr %h, required 1 fffffffc", o_req, o_addr);
        end
        cyc();
        vectors++;
        if (o_req !== 1'b1 || o_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_next: req %b addr %h, required 1 00000000", o_req, o_addr);
        end
        repeat (6) cyc();
    endtask
    task automatic test_err();
        logic exp_err;
`ifdef CV32E40P_PREFETCH_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        err_addr = 32'h404;
        fetch_ready_i = 1'b0;
        do_branch(32'h400);
        repeat (5) cyc();
        for (int k = 0; k < 3; k++) begin
            if (k > 0) begin
                fetch_ready_i = 1'b1;
                cyc();
                fetch_ready_i = 1'b0;
                cyc();
            end
            vectors++;
            if (o_valid !== 1'b1 || o_rdata !== word(32'h400 + 32'(4 * k)) || o_err !== (k == 1 ? exp_err : 1'b0)) begin
                miscompares++;
                $display("FAIL err_head%0d: valid %b rdata %h err %b, required 1 %h %b", k, o_valid, o_rdata,
                         o_err, word(32'h400 + 32'(4 * k)), k == 1 ? exp_err : 1'b0);
            end
        end
        err_addr = 32'h1;
    endtask
    task automatic test_reset_mid();
        fetch_ready_i = 1'b1;
        instr_gnt_i = 1'b0;
        repeat (3) cyc();
        vectors++;
        if (o_req !== 1'b1 || o_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_pending: req %b busy %b, required 1 1", o_req, o_busy);
        end
        rst = 1'b1;
        req_i = 1'b0;
        cyc();
        rst = 1'b0;
        cyc();
        vectors++;
        if (o_req !== 1'b0 || o_addr !== 32'h0 || o_valid !== 1'b0 || o_busy !== 1'b0 || o_err !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_cleared: req %b addr %h valid %b busy %b err %b, required 0 0 0 0 0",
                     o_req, o_addr, o_valid, o_busy, o_err);
        end
        instr_gnt_i = 1'b1;
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end
    initial begin
        vectors = 0; miscompares = 0;
        rst = 1'b1; req_i = 1'b0; branch_i = 1'b0; branch_addr_i = '0; fetch_ready_i = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = '0; instr_err_i = 1'b0;
        resp_hold = 1'b0; err_addr = 32'h1;
        #1;
        test_reset();
        test_sequential();
        test_stall();
        test_branch_wait();
        test_branch_outstanding();
        test_wrap();
        test_err();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
